imm_decode_ctrl: RTL and testbench

- Decode-stage controller that sequences the immediate generator between fetch and execute.
- Accepts fetched instructions over a valid/ready handshake and classifies the opcode into the 2-bit immediate-type select (00 I-type, 01 shift, 10 store, 11 upper).
- Buffers instructions in a 2-entry skid buffer and presents instruction plus select to the immediate generator and execute with 1-cycle latency.
- Supports pipeline flush and flags instructions that carry no immediate or are illegal.

---
 rtl/imm_decode_ctrl.sv | 153 +++++++++++++++
 tb/tb_imm_decode_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller: classifies fetched instructions into an immediate-type
// select and buffers them in a 2-entry skid buffer. Optional counters: IMM_DECODE_CTRL_PERF_EN.
module imm_decode_ctrl #(
  parameter int INST_WIDTH   = 32,
  parameter int IMM_TYPE_NUM = 4,
  parameter int PC_WIDTH     = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [INST_WIDTH-1:0]           in_inst,
  input  logic [PC_WIDTH-1:0]             in_pc,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [INST_WIDTH-1:0]           out_inst,
  output logic [PC_WIDTH-1:0]             out_pc,
  output logic [$clog2(IMM_TYPE_NUM)-1:0] out_imm_type,
  output logic                            out_has_imm,
  output logic                            out_illegal
`ifdef IMM_DECODE_CTRL_PERF_EN
  ,
  input  logic                            perf_clr,
  output logic [31:0]                     perf_stall_cnt,
  output logic [31:0]                     perf_full_cnt
`endif
);

  localparam int TW = $clog2(IMM_TYPE_NUM);
  localparam int PW = INST_WIDTH + PC_WIDTH + TW + 2;

  logic [TW-1:0] cls_type;
  logic          cls_has_imm;
  logic          cls_illegal;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          is_shift_f3;

  assign opcode      = in_inst[6:0];
  assign funct3      = in_inst[14:12];
  assign is_shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    cls_type    = TW'(0);
    cls_has_imm = 1'b0;
    cls_illegal = 1'b0;
    case (opcode)
      7'b0000011, 7'b1100111: cls_has_imm = 1'b1;
      7'b0010011, 7'b0011011: begin
        cls_has_imm = 1'b1;
        cls_type    = is_shift_f3 ? TW'(1) : TW'(0);
      end
      7'b0100011: begin
        cls_has_imm = 1'b1;
        cls_type    = TW'(2);
      end
      7'b0110111, 7'b0010111: begin
        cls_has_imm = 1'b1;
        cls_type    = TW'(3);
      end
      default: cls_illegal = (in_inst[1:0] != 2'b11);
    endcase
  end

  // Payload layout: {inst, pc, imm_type, has_imm, illegal}
  logic [PW-1:0] new_pl;
  logic [PW-1:0] h_pl_q, h_pl_d, s_pl_q, s_pl_d;
  logic          h_vld_q, h_vld_d, s_vld_q, s_vld_d;
  logic          in_ready_q, in_ready_d;
  logic          acc, deq;

  assign new_pl = {in_inst, in_pc, cls_type, cls_has_imm, cls_illegal};
  assign acc    = in_valid && in_ready_q;
  assign deq    = h_vld_q && out_ready;

  always_comb begin
    h_vld_d = h_vld_q;
    s_vld_d = s_vld_q;
    h_pl_d  = h_pl_q;
    s_pl_d  = s_pl_q;
    if (flush) begin
      h_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!h_vld_q) begin
      if (acc) begin
        h_vld_d = 1'b1;
        h_pl_d  = new_pl;
      end
    end else if (!s_vld_q) begin
      if (acc && deq) begin
        h_pl_d = new_pl;
      end else if (acc) begin
        s_vld_d = 1'b1;
        s_pl_d  = new_pl;
      end else if (deq) begin
        h_vld_d = 1'b0;
      end
    end else if (deq) begin
      // Full buffer never accepts, so only the skid-to-head move is possible
      h_pl_d  = s_pl_q;
      s_vld_d = 1'b0;
    end
    in_ready_d = !(h_vld_d && s_vld_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_vld_q    <= 1'b0;
      s_vld_q    <= 1'b0;
      h_pl_q     <= '0;
      s_pl_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      h_vld_q    <= h_vld_d;
      s_vld_q    <= s_vld_d;
      h_pl_q     <= h_pl_d;
      s_pl_q     <= s_pl_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = h_vld_q;
  assign out_inst     = h_pl_q[PW-1 -: INST_WIDTH];
  assign out_pc       = h_pl_q[TW+2 +: PC_WIDTH];
  assign out_imm_type = h_pl_q[2 +: TW];
  assign out_has_imm  = h_pl_q[1];
  assign out_illegal  = h_pl_q[0];

`ifdef IMM_DECODE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, full_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      full_cnt_q  <= '0;
    end else if (perf_clr) begin
      stall_cnt_q <= '0;
      full_cnt_q  <= '0;
    end else begin
      if (h_vld_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (in_valid && !in_ready_q && (full_cnt_q != 32'hFFFF_FFFF))
        full_cnt_q <= full_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_full_cnt  = full_cnt_q;
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed self-checking bench for imm_decode_ctrl; the perf counter test is
// compiled only when IMM_DECODE_CTRL_PERF_EN is defined.
module tb_imm_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [1:0]  out_imm_type;
  logic        out_has_imm;
  logic        out_illegal;
`ifdef IMM_DECODE_CTRL_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_full_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  imm_decode_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_imm_type (out_imm_type),
    .out_has_imm  (out_has_imm),
    .out_illegal  (out_illegal)
`ifdef IMM_DECODE_CTRL_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_full_cnt  (perf_full_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
`ifdef IMM_DECODE_CTRL_PERF_EN
    perf_clr  = 1'b0;
`endif
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_handshake got v/r=%b%b want 01", out_valid, in_ready);
    end
    tests_run++;
    if ({out_inst, out_pc, out_imm_type, out_has_imm, out_illegal} !== '0) begin
      tests_failed++;
      $display("FAIL reset_payload got inst=%h pc=%h t=%b h=%b i=%b want all zero",
               out_inst, out_pc, out_imm_type, out_has_imm, out_illegal);
    end
    $display("[TB] reset: out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  task automatic test_single_pass;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h00A0_0093;
    in_pc     = 64'h1000;
    tick;
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, out_imm_type, out_has_imm, out_illegal} !== 5'b1_00_1_0 ||
        out_inst !== 32'h00A0_0093 || out_pc !== 64'h1000) begin
      tests_failed++;
      $display("FAIL single_pass got v=%b t=%b h=%b i=%b inst=%h pc=%h want v=1 t=00 h=1 i=0 inst=00a00093 pc=1000",
               out_valid, out_imm_type, out_has_imm, out_illegal, out_inst, out_pc);
    end
    $display("[TB] single: inst=%h type=%b", out_inst, out_imm_type);
    tick;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_classify;
    logic [31:0] vi [8];
    logic [3:0]  ve [8];  // {type, has_imm, illegal}
    vi[0] = 32'h0020_9093; ve[0] = 4'b01_1_0;  // slli
    vi[1] = 32'h0020_B023; ve[1] = 4'b10_1_0;  // sd
    vi[2] = 32'h1234_50B7; ve[2] = 4'b11_1_0;  // lui
    vi[3] = 32'h0020_81B3; ve[3] = 4'b00_0_0;  // add
    vi[4] = 32'h0000_0000; ve[4] = 4'b00_0_1;  // all zero
    vi[5] = 32'h4010_D09B; ve[5] = 4'b01_1_0;  // sraiw
    vi[6] = 32'h0010_809B; ve[6] = 4'b00_1_0;  // addiw
    vi[7] = 32'h0000_0517; ve[7] = 4'b11_1_0;  // auipc
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_inst  = vi[i];
      in_pc    = 64'h2000 + 64'(4 * i);
      tick;
      tests_run++;
      if (out_valid !== 1'b1 || out_inst !== vi[i] || out_pc !== 64'h2000 + 64'(4 * i) ||
          {out_imm_type, out_has_imm, out_illegal} !== ve[i]) begin
        tests_failed++;
        $display("FAIL classify[%0d] got v=%b inst=%h pc=%h cls=%b want v=1 inst=%h cls=%b",
                 i, out_valid, out_inst, out_pc, {out_imm_type, out_has_imm, out_illegal}, vi[i], ve[i]);
      end
      $display("[TB] classify: inst=%h cls=%b", out_inst, {out_imm_type, out_has_imm, out_illegal});
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'hA000_0013;
    tick;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_first_ready got in_ready=%b want 1", in_ready);
    end
    in_inst = 32'hB000_0013;
    tick;
    tests_run++;
    if (in_ready !== 1'b0 || out_inst !== 32'hA000_0013) begin
      tests_failed++;
      $display("FAIL bp_full got in_ready=%b inst=%h want 0 a0000013", in_ready, out_inst);
    end
    in_inst = 32'hC000_0013;
    tick;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'hA000_0013) begin
      tests_failed++;
      $display("FAIL bp_hold got in_ready=%b v=%b inst=%h want 0 1 a0000013", in_ready, out_valid, out_inst);
    end
    out_ready = 1'b1;
    tick;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_inst !== 32'hB000_0013) begin
      tests_failed++;
      $display("FAIL bp_drain_b got in_ready=%b v=%b inst=%h want 1 1 b0000013", in_ready, out_valid, out_inst);
    end
    $display("[TB] backpressure: inst=%h", out_inst);
    tick;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_inst !== 32'hC000_0013) begin
      tests_failed++;
      $display("FAIL bp_drain_c got v=%b inst=%h want 1 c0000013", out_valid, out_inst);
    end
    $display("[TB] backpressure: inst=%h", out_inst);
    tick;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int errs = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_inst  = 32'h0000_0013 | (32'(i + 1) << 20);
      tick;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_inst !== (32'h0000_0013 | (32'(i + 1) << 20))) begin
        errs++;
        $display("FAIL b2b[%0d] got v=%b r=%b inst=%h want 1 1 %h", i, out_valid, in_ready, out_inst,
                 32'h0000_0013 | (32'(i + 1) << 20));
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (errs != 0) tests_failed++;
    $display("[TB] back_to_back: 10 issued, %0d cycle errors", errs);
    tick;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h1110_0013;
    tick;
    in_inst = 32'h2220_0013;
    tick;
    in_inst = 32'hDEAD_0013;
    flush   = 1'b1;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL flush_state got v/r=%b%b want 01", out_valid, in_ready);
    end
    tick;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_ghost got out_valid=%b inst=%h want 0", out_valid, out_inst);
    end
    in_valid = 1'b1;
    in_inst  = 32'h3330_0013;
    tick;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_inst !== 32'h3330_0013) begin
      tests_failed++;
      $display("FAIL flush_recover got v=%b inst=%h want 1 33300013", out_valid, out_inst);
    end
    $display("[TB] flush: after recovery inst=%h", out_inst);
    out_ready = 1'b1;
    tick;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h4440_0013;
    tick;
    tick;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01 || out_inst !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset got v/r=%b%b inst=%h want 01 00000000", out_valid, in_ready, out_inst);
    end
    $display("[TB] async_reset: out_valid=%b", out_valid);
    do_reset;
  endtask

`ifdef IMM_DECODE_CTRL_PERF_EN
  task automatic test_perf;
    do_reset;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h5550_0013;
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    tests_run++;
    if (perf_stall_cnt !== 32'd5) begin
      tests_failed++;
      $display("FAIL perf_stall got %0d want 5", perf_stall_cnt);
    end
    perf_clr = 1'b1;
    tick;
    perf_clr = 1'b0;
    tests_run++;
    if (perf_stall_cnt !== 32'd0 || perf_full_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL perf_clr got stall=%0d full=%0d want 0 0", perf_stall_cnt, perf_full_cnt);
    end
    $display("[TB] perf: stall=%0d after clear", perf_stall_cnt);
  endtask
`endif

  initial begin
    test_reset;
    test_single_pass;
    test_classify;
    test_backpressure;
    test_back_to_back;
    test_flush;
    test_async_reset;
`ifdef IMM_DECODE_CTRL_PERF_EN
    test_perf;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
